// File: rtl/fifo_rr_arbiter_if.sv
// fifo_rr_arbiter_if: FIFO-bank facing signals of the round-robin arbiter
interface fifo_rr_arbiter_if #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 6
);
  logic [N_IN-1:0]        in_empty;
  logic [N_IN*DATA_W-1:0] in_data;
  logic [N_IN-1:0]        in_err;
  logic [N_IN-1:0]        in_pop;
  logic [3:0]             out_al_full;
  logic [3:0]             out_err;
  logic [3:0]             out_push;
  logic [DATA_W-1:0]      out_data;
  modport master (
    input  in_empty, in_data, in_err, out_al_full, out_err,
    output in_pop, out_push, out_data
  );
  modport slave (
    output in_empty, in_data, in_err, out_al_full, out_err,
    input  in_pop, out_push, out_data
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin pop of input FIFOs, routed push to 4 output FIFOs by data[5:4]
module fifo_rr_arbiter #(
  parameter int N_IN         = 4,
  parameter int DATA_W       = 6,
  parameter int TH_W         = 4,
  parameter int DEF_AL_FULL  = 6,
  parameter int DEF_AL_EMPTY = 1
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             init,
  input  logic [TH_W-1:0]  cfg_al_full,
  input  logic [TH_W-1:0]  cfg_al_empty,
  fifo_rr_arbiter_if.master bus,
  output logic [TH_W-1:0]  th_al_full,
  output logic [TH_W-1:0]  th_al_empty,
  output logic             idle,
  output logic             error
);
  localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;
  typedef enum logic [2:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE, S_ERROR} state_t;
  state_t            state, state_nx;
  logic              err, gnt, v1;
  logic [PW-1:0]     rr_ptr, gnt_idx, sel, idx;
  logic [N_IN-1:0]   req;
  logic [DATA_W-1:0] word;
  assign err   = (|bus.in_err) | (|bus.out_err);
  assign idle  = state == S_IDLE;
  assign error = state == S_ERROR;
  // an error in the same cycle suppresses the grant so nothing is popped only to be dropped
  assign req = (state == S_ACTIVE && !err && !(|bus.out_al_full)) ? ~bus.in_empty : '0;
  always_comb begin
    gnt     = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      idx = rr_ptr + PW'(k);
      if (req[idx]) begin
        gnt     = 1'b1;
        gnt_idx = idx;
      end
    end
  end
  assign bus.in_pop = gnt ? N_IN'(1) << gnt_idx : '0;
  // FIFO read data arrives the cycle after the pop, so it is sampled via the registered port index
  assign word = bus.in_data[sel*DATA_W +: DATA_W];
  always_comb begin
    state_nx = state;
    if (state == S_RESET)
      state_nx = S_INIT;
    else if (err)
      state_nx = S_ERROR;
    else if (state == S_INIT)
      state_nx = init ? S_INIT : S_IDLE;
    else if (state == S_IDLE)
      state_nx = init ? S_INIT : (~&bus.in_empty ? S_ACTIVE : S_IDLE);
    else if (state == S_ACTIVE)
      state_nx = (&bus.in_empty && !v1 && !(|bus.out_push)) ? S_IDLE : S_ACTIVE;
  end
  always_ff @(posedge clk or posedge RESET)
    if (RESET) state <= S_RESET;
    else       state <= state_nx;
  always_ff @(posedge clk or posedge RESET)
    if (RESET) begin
      rr_ptr       <= '0;
      sel          <= '0;
      v1           <= 1'b0;
      bus.out_push <= '0;
      bus.out_data <= '0;
      th_al_full   <= TH_W'(DEF_AL_FULL);
      th_al_empty  <= TH_W'(DEF_AL_EMPTY);
    end else begin
      if (state == S_INIT && init) begin
        th_al_full  <= cfg_al_full;
        th_al_empty <= cfg_al_empty;
      end
      rr_ptr       <= gnt ? gnt_idx + PW'(1) : rr_ptr;
      sel          <= gnt ? gnt_idx : sel;
      v1           <= gnt;
      bus.out_push <= (v1 && !err) ? 4'(1) << word[DATA_W-1 -: 2] : 4'b0;
      bus.out_data <= (v1 && !err) ? word : bus.out_data;
    end
endmodule
